// File: rtl/npu_cmd_pkg.sv
// Shared types and constants for the host PIO command path: opcode encoding,
// command word layout, scheduler states and status word bit positions.
package npu_cmd_pkg;

   localparam int unsigned PIO_W     = 32;
   localparam int unsigned PAYLOAD_W = 30;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_STORE = 2'b01,
      OP_MOVE  = 2'b10,
      OP_FENCE = 2'b11
   } opcode_e;

   typedef struct packed {
      opcode_e                op;
      logic [PAYLOAD_W-1:0]   payload;
   } pio_cmd_t;

   typedef enum logic [1:0] {
      S_IDLE       = 2'b00,
      S_ISSUE      = 2'b01,
      S_FENCE_WAIT = 2'b10
   } sched_state_e;

   // Status word layout returned on f2h_pio32
   localparam int unsigned ST_MV_DONE      = 31;
   localparam int unsigned ST_SD_DONE      = 30;
   localparam int unsigned ST_OVF          = 29;
   localparam int unsigned ST_FENCE_WAIT   = 28;
   localparam int unsigned ST_IDLE         = 27;
   localparam int unsigned ST_FIFO_CNT_LSB = 16;
   localparam int unsigned ST_DONE_CNT_LSB = 0;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; a pop in the same cycle frees a slot for a push
// even when full. Head entry is read combinationally from the read pointer.
module cmd_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_push,
   input  logic [WIDTH-1:0]        i_data,
   input  logic                    i_pop,
   output logic [WIDTH-1:0]        o_head,
   output logic [$clog2(DEPTH):0]  o_count,
   output logic                    o_full,
   output logic                    o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

endmodule

// File: rtl/pio_cmd_sched.sv
// Host PIO command scheduler: queues command words, dispatches them in order to
// the SDRAM and line-move engines, and reports a registered status word.
module pio_cmd_sched
   import npu_cmd_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PIO_W-1:0]      h2f_pio32,
   input  logic                  h2f_write,
   input  logic                  err_clr,
   output logic [PIO_W-1:0]      f2h_pio32,
   output logic                  f2h_write,
   output logic                  sd_start,
   output logic                  sd_store,
   output logic [PAYLOAD_W-1:0]  sd_cmd,
   input  logic                  sd_done,
   output logic                  mv_start,
   output logic [PAYLOAD_W-1:0]  mv_cmd,
   input  logic                  mv_done
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   pio_cmd_t         w_head;
   logic [CW-1:0]    w_count;
   logic [CW-1:0]    w_count_next;
   logic             w_full;
   logic             w_empty;

   sched_state_e     r_state;
   sched_state_e     w_state_next;
   logic             r_sd_busy;
   logic             r_mv_busy;
   logic             r_ovf;
   logic [CNT_W-1:0] r_done_cnt;
   logic [PIO_W-1:0] r_status;
   logic             r_f2h_write;
   logic             r_sd_start;
   logic             r_sd_store;
   logic [PAYLOAD_W-1:0] r_sd_cmd;
   logic             r_mv_start;
   logic [PAYLOAD_W-1:0] r_mv_cmd;

   logic             w_sd_issue;
   logic             w_mv_issue;
   logic             w_fence_pop;
   logic             w_pop;
   logic             w_drop;
   logic             w_push_ok;
   logic             w_sd_acc;
   logic             w_mv_acc;
   logic             w_sd_busy_next;
   logic             w_mv_busy_next;
   logic             w_ovf_next;
   logic [CNT_W-1:0] w_done_cnt_next;
   logic [PIO_W-1:0] w_status;

   cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (PIO_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (h2f_write),
      .i_data  (h2f_pio32),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Head decode: a busy flag blocks its engine, so a same-cycle done defers issue
   always_comb begin
      w_sd_issue  = 1'b0;
      w_mv_issue  = 1'b0;
      w_fence_pop = 1'b0;
      case (r_state)
         S_FENCE_WAIT: w_fence_pop = !r_sd_busy && !r_mv_busy;
         default: begin
            if (!w_empty) begin
               case (w_head.op)
                  OP_LOAD, OP_STORE: w_sd_issue  = !r_sd_busy;
                  OP_MOVE:           w_mv_issue  = !r_mv_busy;
                  default:           w_fence_pop = !r_sd_busy && !r_mv_busy;
               endcase
            end
         end
      endcase
   end

   assign w_pop        = w_sd_issue || w_mv_issue || w_fence_pop;
   assign w_drop       = h2f_write && w_full && !w_pop;
   assign w_push_ok    = h2f_write && !w_drop;
   assign w_count_next = w_count + CW'(w_push_ok) - CW'(w_pop);

   always_comb begin
      w_state_next = r_state;
      if (!w_empty && (w_head.op == OP_FENCE) && !w_fence_pop)
         w_state_next = S_FENCE_WAIT;
      else if (w_count_next == '0)
         w_state_next = S_IDLE;
      else
         w_state_next = S_ISSUE;
   end

   assign w_sd_acc        = sd_done && r_sd_busy;
   assign w_mv_acc        = mv_done && r_mv_busy;
   assign w_sd_busy_next  = w_sd_issue || (r_sd_busy && !w_sd_acc);
   assign w_mv_busy_next  = w_mv_issue || (r_mv_busy && !w_mv_acc);
   assign w_ovf_next      = w_drop || (r_ovf && !err_clr);
   assign w_done_cnt_next = r_done_cnt + CNT_W'(w_sd_acc) + CNT_W'(w_mv_acc)
                          + CNT_W'(w_fence_pop);

   // Status reflects the state being loaded on this edge
   always_comb begin
      w_status                                  = '0;
      w_status[ST_MV_DONE]                      = w_mv_acc;
      w_status[ST_SD_DONE]                      = w_sd_acc;
      w_status[ST_OVF]                          = w_ovf_next;
      w_status[ST_FENCE_WAIT]                   = (w_state_next == S_FENCE_WAIT);
      w_status[ST_IDLE]                         = (w_count_next == '0) &&
                                                  !w_sd_busy_next && !w_mv_busy_next;
      w_status[ST_FIFO_CNT_LSB +: 8]            = 8'(w_count_next);
      w_status[ST_DONE_CNT_LSB +: 16]           = 16'(w_done_cnt_next);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state           <= S_IDLE;
         r_sd_busy         <= 1'b0;
         r_mv_busy         <= 1'b0;
         r_ovf             <= 1'b0;
         r_done_cnt        <= '0;
         r_status          <= '0;
         r_status[ST_IDLE] <= 1'b1;
         r_f2h_write       <= 1'b0;
         r_sd_start        <= 1'b0;
         r_sd_store        <= 1'b0;
         r_sd_cmd          <= '0;
         r_mv_start        <= 1'b0;
         r_mv_cmd          <= '0;
      end else begin
         r_state     <= w_state_next;
         r_sd_busy   <= w_sd_busy_next;
         r_mv_busy   <= w_mv_busy_next;
         r_ovf       <= w_ovf_next;
         r_done_cnt  <= w_done_cnt_next;
         r_status    <= w_status;
         r_f2h_write <= (w_status != r_status);
         r_sd_start  <= w_sd_issue;
         r_sd_store  <= w_sd_issue && (w_head.op == OP_STORE);
         r_mv_start  <= w_mv_issue;
         if (w_sd_issue) r_sd_cmd <= w_head.payload;
         if (w_mv_issue) r_mv_cmd <= w_head.payload;
      end
   end

   assign f2h_pio32 = r_status;
   assign f2h_write = r_f2h_write;
   assign sd_start  = r_sd_start;
   assign sd_store  = r_sd_store;
   assign sd_cmd    = r_sd_cmd;
   assign mv_start  = r_mv_start;
   assign mv_cmd    = r_mv_cmd;

endmodule

// File: tb/tb_pio_cmd_sched.sv
// Bench for pio_cmd_sched: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the scheduling rules.
module tb_pio_cmd_sched;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] h2f_pio32;
   logic        h2f_write;
   logic        err_clr;
   logic [31:0] f2h_pio32;
   logic        f2h_write;
   logic        sd_start;
   logic        sd_store;
   logic [29:0] sd_cmd;
   logic        sd_done;
   logic        mv_start;
   logic [29:0] mv_cmd;
   logic        mv_done;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_q[$];
   bit          m_sd_b;
   bit          m_mv_b;
   bit          m_ovf;
   int          m_cnt;
   logic [31:0] e_status;
   logic        e_f2h_write;
   logic        e_sd_start;
   logic        e_sd_store;
   logic [29:0] e_sd_cmd;
   logic        e_mv_start;
   logic [29:0] e_mv_cmd;

   always #5 clk = ~clk;

   pio_cmd_sched #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .h2f_pio32 (h2f_pio32),
      .h2f_write (h2f_write),
      .err_clr   (err_clr),
      .f2h_pio32 (f2h_pio32),
      .f2h_write (f2h_write),
      .sd_start  (sd_start),
      .sd_store  (sd_store),
      .sd_cmd    (sd_cmd),
      .sd_done   (sd_done),
      .mv_start  (mv_start),
      .mv_cmd    (mv_cmd),
      .mv_done   (mv_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_sd_b      = 0;
      m_mv_b      = 0;
      m_ovf       = 0;
      m_cnt       = 0;
      e_status    = 32'h0800_0000;
      e_f2h_write = 0;
      e_sd_start  = 0;
      e_sd_store  = 0;
      e_sd_cmd    = '0;
      e_mv_start  = 0;
      e_mv_cmd    = '0;
   endtask

   // One clock of the scheduling rules applied to the inputs sampled at the edge
   task automatic model_edge(input bit wr, input logic [31:0] w, input bit clr,
                             input bit sdd, input bit mvd);
      bit sd_go = 0, mv_go = 0, f_pop = 0, f_wait = 0, ovf_set = 0;
      bit sd_acc, mv_acc;
      logic [31:0] head;
      logic [31:0] nxt;
      if (m_q.size() > 0) begin
         head = m_q[0];
         case (head[31:30])
            2'd0, 2'd1: sd_go = !m_sd_b;
            2'd2:       mv_go = !m_mv_b;
            default:    if (!m_sd_b && !m_mv_b) f_pop = 1; else f_wait = 1;
         endcase
      end else begin
         head = '0;
      end
      sd_acc     = sdd && m_sd_b;
      mv_acc     = mvd && m_mv_b;
      e_sd_start = sd_go;
      e_sd_store = sd_go && head[30];
      e_mv_start = mv_go;
      if (sd_go) e_sd_cmd = head[29:0];
      if (mv_go) e_mv_cmd = head[29:0];
      if (sd_go || mv_go || f_pop) void'(m_q.pop_front());
      if (wr) begin
         if (m_q.size() < DEPTH) m_q.push_back(w);
         else ovf_set = 1;
      end
      if (ovf_set) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (sd_go) m_sd_b = 1; else if (sd_acc) m_sd_b = 0;
      if (mv_go) m_mv_b = 1; else if (mv_acc) m_mv_b = 0;
      m_cnt = (m_cnt + int'(sd_acc) + int'(mv_acc) + int'(f_pop)) % (1 << CNT_W);
      nxt = {mv_acc, sd_acc, m_ovf, f_wait,
             (m_q.size() == 0) && !m_sd_b && !m_mv_b, 3'b000,
             8'(m_q.size()), 16'(m_cnt)};
      e_f2h_write = (nxt != e_status);
      e_status    = nxt;
   endtask

   task automatic cycle(input bit wr = 0, input logic [31:0] w = '0, input bit clr = 0,
                        input bit sdd = 0, input bit mvd = 0);
      h2f_write = wr;
      h2f_pio32 = w;
      err_clr   = clr;
      sd_done   = sdd;
      mv_done   = mvd;
      @(posedge clk);
      model_edge(wr, w, clr, sdd, mvd);
      #1;
      chk("sd_start",  32'(sd_start),  32'(e_sd_start));
      chk("sd_store",  32'(sd_store),  32'(e_sd_store));
      chk("sd_cmd",    32'(sd_cmd),    32'(e_sd_cmd));
      chk("mv_start",  32'(mv_start),  32'(e_mv_start));
      chk("mv_cmd",    32'(mv_cmd),    32'(e_mv_cmd));
      chk("f2h_pio32", f2h_pio32,      e_status);
      chk("f2h_write", 32'(f2h_write), 32'(e_f2h_write));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_status"},   f2h_pio32,       32'h0800_0000);
      chk({tag, "_f2h_wr"},   32'(f2h_write),  32'd0);
      chk({tag, "_sd_start"}, 32'(sd_start),   32'd0);
      chk({tag, "_sd_store"}, 32'(sd_store),   32'd0);
      chk({tag, "_sd_cmd"},   32'(sd_cmd),     32'd0);
      chk({tag, "_mv_start"}, 32'(mv_start),   32'd0);
      chk({tag, "_mv_cmd"},   32'(mv_cmd),     32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      h2f_pio32 = '0;
      h2f_write = 1'b0;
      err_clr   = 1'b0;
      sd_done   = 1'b0;
      mv_done   = 1'b0;
      model_reset();
      #12;
      chk_reset_outputs("reset");
      rst = 1'b0;

      // Single LOAD: start two cycles after the write, then completion
      cycle(1, 32'h0000_00A6);
      chk("t1_no_start_yet", 32'(sd_start), 32'd0);
      cycle();
      chk("t1_sd_start", 32'(sd_start), 32'd1);
      chk("t1_sd_cmd",   32'(sd_cmd),   32'h0000_00A6);
      cycle(0, '0, 0, 1, 0);
      chk("t1_sd_done_bit", 32'(f2h_pio32[30]), 32'd1);
      chk("t1_count",       32'(f2h_pio32[15:0]), 32'd1);
      cycle();
      chk("t1_sd_done_pulse", 32'(f2h_pio32[30]), 32'd0);

      // LOAD then MOVE back to back: both in flight together
      cycle(1, 32'h0000_0011);
      cycle(1, 32'h8002_9CA6);
      chk("t2_sd_start", 32'(sd_start), 32'd1);
      cycle();
      chk("t2_mv_start", 32'(mv_start), 32'd1);
      chk("t2_mv_cmd",   32'(mv_cmd),   32'h0002_9CA6);
      cycle(0, '0, 0, 1, 0);
      cycle(0, '0, 0, 0, 1);
      cycle();
      chk("t2_count", 32'(f2h_pio32[15:0]), 32'd3);

      // LOAD, FENCE, MOVE: MOVE held until the fence drains
      cycle(1, 32'h0000_0123);
      cycle(1, 32'hC000_0000);
      cycle(1, 32'h8000_0055);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t3_fence_wait", 32'(f2h_pio32[28]), 32'd1);
         chk("t3_mv_held",    32'(mv_start),      32'd0);
      end
      cycle(0, '0, 0, 1, 0);
      chk("t3_mv_held_done", 32'(mv_start), 32'd0);
      cycle();
      chk("t3_fence_clear", 32'(f2h_pio32[28]), 32'd0);
      chk("t3_mv_held_pop", 32'(mv_start),      32'd0);
      cycle();
      chk("t3_mv_start", 32'(mv_start), 32'd1);
      cycle(0, '0, 0, 0, 1);
      cycle();
      chk("t3_count", 32'(f2h_pio32[15:0]), 32'd6);

      // Overflow with a stalled SDRAM engine
      for (int i = 0; i < DEPTH + 2; i++) cycle(1, 32'h0000_0200 + 32'(i));
      chk("t4_ovf",       32'(f2h_pio32[29]),    32'd1);
      chk("t4_fifo_cnt",  32'(f2h_pio32[23:16]), 32'(DEPTH));
      cycle(1, 32'h0000_0300, 1);
      chk("t4_set_wins",  32'(f2h_pio32[29]),    32'd1);
      cycle(0, '0, 1);
      chk("t4_ovf_clr",   32'(f2h_pio32[29]),    32'd0);
      cycle(0, '0, 0, 1, 0);
      cycle(1, 32'h0000_0301);
      chk("t4_full_pushpop_ovf", 32'(f2h_pio32[29]),    32'd0);
      chk("t4_full_pushpop_cnt", 32'(f2h_pio32[23:16]), 32'(DEPTH));
      for (int i = 0; i < 40; i++) begin
         if (m_q.size() == 0 && !m_sd_b) break;
         cycle(0, '0, 0, 1, 0);
         cycle();
      end
      chk("t4_drained_idle", 32'(f2h_pio32[27]),   32'd1);
      chk("t4_count",        32'(f2h_pio32[15:0]), 32'd12);

      // Spurious move completion
      cycle(0, '0, 0, 0, 1);
      chk("t5_no_write",  32'(f2h_write), 32'd0);
      chk("t5_status",    f2h_pio32,      32'h0800_000C);

      // Reset mid-operation
      for (int i = 0; i < 4; i++) cycle(1, 32'h0000_0400 + 32'(i));
      rst = 1'b1;
      #1;
      chk_reset_outputs("t6_rst");
      rst = 1'b0;
      model_reset();
      cycle(0, '0, 0, 1, 0);
      chk("t6_done_ignored", f2h_pio32,      32'h0800_0000);
      chk("t6_no_write",     32'(f2h_write), 32'd0);

      // Random traffic against the model
      for (int i = 0; i < 2000; i++) begin
         cycle(($urandom_range(0, 1) == 1), $urandom(), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
